// File: rtl/clock_divider_by3.sv
// -----------------------------------------------------------------------------
// clock_divider_by3
//
// Purpose:
//   Free-running divide-by-3 clock generator with a 50% duty-cycle output.
//   A modulo-3 counter on the rising edge of clk_i marks one cycle in three.
//   A rising-edge flop (r_pos_q) pulses high for that cycle. A falling-edge
//   flop (r_neg_q) repeats the pulse half a period later. The OR of the two
//   is high for 1.5 input periods and low for 1.5 input periods.
//
// Ports:
//   clk_i    in   1  input clock (rising edge for all state, plus one
//                    falling-edge flop)
//   reset_i  in   1  synchronous, active-high reset
//   clk_o    out  1  divided clock, f(clk_i)/3, 50% duty cycle
// -----------------------------------------------------------------------------
module clock_divider_by3 (
    input  logic clk_i,
    input  logic reset_i,
    output logic clk_o
);

    logic [1:0] r_cnt;
    logic       r_pos_q;
    logic       r_neg_q;
    logic       w_cnt_wrap;
    logic [1:0] w_cnt_next;

    // Terminal count of the modulo-3 sequence 0,1,2.
    assign w_cnt_wrap = (r_cnt == 2'd2);

    // Illegal value 3 (e.g. after an upset) also returns to 0.
    always_comb begin
        w_cnt_next = 2'd0;
        if (!w_cnt_wrap && (r_cnt != 2'd3))
            w_cnt_next = r_cnt + 2'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt   <= 2'd0;
            r_pos_q <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_pos_q <= w_cnt_wrap;
        end
    end

    // Half-cycle delayed copy of r_pos_q.
    // While reset is held r_pos_q is already 0, so the value of reset_i
    // sampled near a falling edge does not matter.
    always_ff @(negedge clk_i) begin
        if (reset_i)
            r_neg_q <= 1'b0;
        else
            r_neg_q <= r_pos_q;
    end

    // The two pulses overlap by half a cycle, so the OR has no runt pulse.
    assign clk_o = r_pos_q | r_neg_q;

endmodule

// File: tb/tb_clock_divider_by3.sv
`timescale 1ns/100ps
module tb_clock_divider_by3;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    logic clk_o;

    int n_pass  = 0;
    int n_total = 0;

    clock_divider_by3 dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clk_o   (clk_o)
    );

    // 10 ns period, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    // Bounded search for a rising edge of clk_o, sampled 0.1 ns after each
    // rising edge of clk_i. Returns with time just past the edge that raised it.
    task automatic wait_clk_o_rise(output bit found);
        logic prev;
        found = 1'b0;
        @(posedge clk_i); #0.1;
        prev = clk_o;
        for (int k = 0; k < 12 && !found; k++) begin
            @(posedge clk_i); #0.1;
            if (clk_o === 1'b1 && prev === 1'b0) found = 1'b1;
            prev = clk_o;
        end
    endtask

    // First rising edge under reset forces clk_o and cnt to 0.
    task automatic test_reset();
        #7.5;
        n_total++;
        if (clk_o !== 1'b0) $display("FAIL reset_clk_o: got %b expected 0", clk_o);
        else n_pass++;
        n_total++;
        if (dut.r_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d expected 0", dut.r_cnt);
        else n_pass++;
        #2.5; // t = 10
    endtask

    // Release at 10 ns. Sample every 1 ns over 200 ns. Expect rises at 35+30k
    // and falls at 50+30k, with 6 complete periods.
    task automatic test_release_steady();
        logic prev;
        int   tn, last_rise, n_rise, n_fall;
        logic exp_v;
        reset_i   = 1'b0;
        prev      = 1'b0;
        last_rise = -1;
        n_rise    = 0;
        n_fall    = 0;
        #0.5;
        for (int i = 0; i < 200; i++) begin
            tn    = 10 + i;
            exp_v = (tn >= 35) && (((tn - 35) % 30) < 15);
            n_total++;
            if (clk_o !== exp_v)
                $display("FAIL wave_t%0d: got %b expected %b", tn, clk_o, exp_v);
            else n_pass++;
            if (clk_o === 1'b1 && prev === 1'b0) begin
                if (last_rise >= 0) begin
                    n_total++;
                    if (tn - last_rise != 30)
                        $display("FAIL period_at_%0d: got %0d ns expected 30", tn, tn - last_rise);
                    else n_pass++;
                end
                last_rise = tn;
                n_rise++;
            end
            if (clk_o === 1'b0 && prev === 1'b1) begin
                n_total++;
                if (tn - last_rise != 15)
                    $display("FAIL high_at_%0d: got %0d ns expected 15", tn, tn - last_rise);
                else n_pass++;
                n_fall++;
            end
            prev = clk_o;
            #1;
        end
        n_total++;
        if (n_rise != 6) $display("FAIL rise_count: got %0d expected 6", n_rise);
        else n_pass++;
        n_total++;
        if (n_fall != 6) $display("FAIL fall_count: got %0d expected 6", n_fall);
        else n_pass++;
    endtask

    // Reset held for 50 cycles. Output and counter stay at 0.
    // On release, clk_o rises on the 3rd rising edge.
    task automatic test_held_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i); #1;
            n_total++;
            if (clk_o !== 1'b0 || dut.r_cnt !== 2'd0)
                $display("FAIL held_pos_%0d: clk_o=%b cnt=%0d expected 0/0", i, clk_o, dut.r_cnt);
            else n_pass++;
            @(negedge clk_i); #1;
            n_total++;
            if (clk_o !== 1'b0)
                $display("FAIL held_neg_%0d: got %b expected 0", i, clk_o);
            else n_pass++;
        end
        reset_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk_i); #1;
            n_total++;
            if (clk_o !== (k == 3))
                $display("FAIL held_release_e%0d: got %b expected %b", k, clk_o, (k == 3));
            else n_pass++;
        end
    endtask

    // Reset asserted right after the edge that raised clk_o. clk_o is low by
    // the falling edge after the reset-sampling edge. Restart takes 3 edges.
    task automatic test_reset_while_high();
        bit found;
        wait_clk_o_rise(found);
        n_total++;
        if (!found) $display("FAIL high_wait: clk_o rise not seen within budget");
        else n_pass++;
        #0.9;
        reset_i = 1'b1;
        @(posedge clk_i); #1;      // reset sampled; r_neg_q still holds clk_o high
        reset_i = 1'b0;
        @(negedge clk_i); #1;
        n_total++;
        if (clk_o !== 1'b0) $display("FAIL high_cleared: got %b expected 0", clk_o);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk_i); #1;
            n_total++;
            if (clk_o !== (k == 3))
                $display("FAIL high_release_e%0d: got %b expected %b", k, clk_o, (k == 3));
            else n_pass++;
        end
        @(negedge clk_i); #1;
        n_total++;
        if (clk_o !== 1'b1) $display("FAIL high_release_neg: got %b expected 1", clk_o);
        else n_pass++;
        @(posedge clk_i); #1;
        n_total++;
        if (clk_o !== 1'b1) $display("FAIL high_release_e4: got %b expected 1", clk_o);
        else n_pass++;
        @(negedge clk_i); #1;
        n_total++;
        if (clk_o !== 1'b0) $display("FAIL high_release_fall: got %b expected 0", clk_o);
        else n_pass++;
    endtask

    // One-cycle reset while cnt=1 (clk_o low). There is no extra pulse, and
    // the first rise comes on the 3rd edge after release.
    task automatic test_reset_while_low();
        bit found;
        wait_clk_o_rise(found);
        n_total++;
        if (!found) $display("FAIL low_wait: clk_o rise not seen within budget");
        else n_pass++;
        @(posedge clk_i); #1;      // cnt now 1
        n_total++;
        if (dut.r_cnt !== 2'd1) $display("FAIL low_cnt: got %0d expected 1", dut.r_cnt);
        else n_pass++;
        @(negedge clk_i); #1;      // falling edge after clk_o's scheduled fall
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        n_total++;
        if (clk_o !== 1'b0 || dut.r_cnt !== 2'd0)
            $display("FAIL low_in_reset: clk_o=%b cnt=%0d expected 0/0", clk_o, dut.r_cnt);
        else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i); #1;
            n_total++;
            if (clk_o !== 1'b0) $display("FAIL low_extra_pulse_%0d: got %b expected 0", k, clk_o);
            else n_pass++;
            @(posedge clk_i); #1;
            n_total++;
            if (clk_o !== (k == 3))
                $display("FAIL low_release_e%0d: got %b expected %b", k, clk_o, (k == 3));
            else n_pass++;
        end
    endtask

    // 1 ns sampling over 20 periods starting at a rise. Expect exactly 20
    // rises and 20 falls, and every high/low run exactly 15 ns.
    task automatic test_glitch();
        bit   found;
        logic prev;
        int   last_edge, n_rise, n_fall, width;
        wait_clk_o_rise(found);
        n_total++;
        if (!found) $display("FAIL glitch_wait: clk_o rise not seen within budget");
        else n_pass++;
        #0.4;                       // sample 0.5 ns past the rise
        prev      = 1'b1;
        last_edge = 0;
        n_rise    = 1;
        n_fall    = 0;
        for (int i = 1; i < 600; i++) begin
            #1;
            if (clk_o !== prev) begin
                width = i - last_edge;
                n_total++;
                if (width != 15)
                    $display("FAIL glitch_width_%0d: got %0d ns expected 15", i, width);
                else n_pass++;
                if (clk_o === 1'b1) n_rise++;
                else n_fall++;
                last_edge = i;
                prev = clk_o;
            end
        end
        n_total++;
        if (n_rise != 20) $display("FAIL glitch_rises: got %0d expected 20", n_rise);
        else n_pass++;
        n_total++;
        if (n_fall != 20) $display("FAIL glitch_falls: got %0d expected 20", n_fall);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_release_steady();
        test_held_reset();
        test_reset_while_high();
        test_reset_while_low();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
